vfadd_sequencer: RTL and testbench
==================================

VFADD_SEQUENCER -- requirements
Module: vfadd_sequencer

Interface
REQ-001 SHALL have parameter MAX_VL, default 32, maximum vector length in elements.
REQ-002 SHALL have parameter LAT, default 3, fixed adder-plus-exception-stage latency in cycles, at least 1.
REQ-003 SHALL have parameter IW, default $clog2(MAX_VL), element index width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  one-cycle command strobe.
REQ-007 vl  input  IW+1  element count, sampled on accepted start.
REQ-008 op_sub  input  1  subtract when 1, sampled on accepted start.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 iss_valid  output  1  element operand request to the adder lane.
REQ-012 iss_idx  output  IW  index of the element being issued.
REQ-013 iss_sub  output  1  latched op_sub driven with every issue.
REQ-014 iss_stall  input  1  lane back-pressure; no issue in a cycle where it is high.
REQ-015 res  input  34  lane result {valid, mask, data[31:0]}, arriving in order.
REQ-016 wr_en  output  1  register-file write strobe.
REQ-017 wr_idx  output  IW  register-file write element index.
REQ-018 wr_data  output  32  register-file write data.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, DRAIN and FIN.
REQ-020 start in IDLE SHALL be accepted; start in any other state SHALL be ignored.
REQ-021 IDLE, accepted start with vl>0: latch vl and op_sub, clear counters, go to ISSUE.
REQ-022 IDLE, accepted start with vl==0: go to FIN with no issue and no write.
REQ-023 vl greater than MAX_VL SHALL be saturated to MAX_VL.
REQ-024 ISSUE: iss_valid = ~iss_stall; each issue SHALL increment iss_idx; after the issue of index vl-1, go to DRAIN.
REQ-025 Each result SHALL be consumed exactly one cycle after res[33] (valid) is high.
REQ-026 A result with mask=1 SHALL produce wr_en=1, wr_idx = write counter, and wr_data = res[31:0], registered with 1-cycle latency.
REQ-027 A result with mask=0 SHALL suppress the write but still advance the write counter.
REQ-028 DRAIN: when the result for index vl-1 is consumed, go to FIN.
REQ-029 FIN: done=1 for exactly one cycle, then go to IDLE.
REQ-030 busy SHALL be high in ISSUE, DRAIN and FIN.
REQ-031 An outstanding counter (width $clog2(LAT+1)+1) SHALL count issued-minus-returned elements; issue and return in the same cycle leave it unchanged.
REQ-032 A result arriving while outstanding==0 SHALL be dropped (protocol error, no write).
REQ-033 The write and issue counters SHALL never wrap; they are bounded by the latched vl.

Reset
REQ-034 rst SHALL force state IDLE and clear all counters and latched fields.
REQ-035 Under rst, busy, done, iss_valid, iss_idx, iss_sub, wr_en, wr_idx and wr_data SHALL all be 0.
REQ-036 rst mid-operation SHALL abort with no done pulse; later results SHALL be dropped under REQ-032.

Configuration
REQ-037 With VFADD_SEQ_EXC_FLAG_EN defined, the block SHALL add output exc_flag (1 bit) and output exc_cnt (IW+1 bits).
REQ-038 exc_flag/exc_cnt SHALL count results with valid=1, mask=0 and data==0 (the lane's Inf/NaN encoding), clear on accepted start, and hold after done.
REQ-039 Without VFADD_SEQ_EXC_FLAG_EN, those ports and their logic SHALL be absent and all other behaviour identical.

Structure
REQ-040 The FSM state encoding and the result-field bit positions (RES_VALID=33, RES_MASK=32, data 31:0) SHALL live in shared package vecunit_pkg.
REQ-041 No sub-module is needed; the outstanding counter may be split into a vfadd_credit_cnt sub-module.

Verification
REQ-042 vl=4, no stall, all mask=1: issues idx 0-3 on consecutive cycles; writes idx 0-3 in order; done one cycle after the last write.
REQ-043 vl=0: done pulses 1 cycle after start; no iss_valid, no wr_en.
REQ-044 vl=3 with iss_stall high on the second cycle: idx 1 is issued one cycle late; all 3 writes still occur in order.
REQ-045 vl=2, result 1 = {1,0,32'h0} with the macro defined: only idx 0 is written; exc_flag=1, exc_cnt=1.
REQ-046 rst asserted while in DRAIN: next cycle all outputs are 0, no done pulse; a late result produces no write.
REQ-047 start pulsed while busy: ignored, and the latched vl is unchanged.

Source files
------------

// File: rtl/vecunit_pkg.sv
// Shared definitions for the vector FP-add sequencer: FSM encoding and lane result layout.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package vecunit_pkg;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } seq_state_t;

   // Lane result word layout: {valid, mask, data[31:0]}
   localparam int RES_VALID = 33;
   localparam int RES_MASK  = 32;
   localparam int DATA_W    = 32;
   localparam int RES_W     = 34;

   typedef struct packed {
      logic              vld;
      logic              mask;
      logic [DATA_W-1:0] dat;
   } res_t;

   // The lane reports Inf/NaN as a masked-off result carrying all-zero data.
   function automatic logic is_exc(input res_t r);
      return r.vld && !r.mask && (r.dat == '0);
   endfunction

endpackage

// File: rtl/vfadd_credit_cnt.sv
// Outstanding-element counter: issued minus returned lane operations.
// Latency: count updates one cycle after inc/dec; simultaneous inc and dec leave it unchanged.
// Backpressure: none; the caller only decrements when the count is non-zero.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        clear to zero (new command)
//   inc, dec   one element issued / one element returned
//   cnt        current outstanding count
module vfadd_credit_cnt #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && !dec) begin
         cnt <= cnt + CW'(1);
      end else if (dec && !inc) begin
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/vfadd_sequencer.sv
// Vector FP-add sequencer: issues vl element ops to a fixed-latency adder lane and writes results back.
// Latency: first issue 1 cycle after start; each result written 1 cycle after it arrives; done 1 cycle after last consume.
// Backpressure: iss_stall holds issue for that cycle; results cannot be back-pressured and are consumed as they arrive.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, vl, op_sub        command strobe, element count (saturated to MAX_VL), subtract select
//   busy, done               command in flight / one-cycle completion pulse
//   iss_valid/idx/sub        element issue to the lane; iss_stall blocks issue
//   res                      lane result {valid, mask, data}, in order
//   wr_en/idx/data           register-file write port
//   exc_flag, exc_cnt        only with VFADD_SEQ_EXC_FLAG_EN: count of Inf/NaN results
module vfadd_sequencer
   import vecunit_pkg::*;
#(
   parameter int MAX_VL = 32,
   parameter int LAT    = 3,
   parameter int IW     = $clog2(MAX_VL)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IW:0]       vl,
   input  logic              op_sub,
   output logic              busy,
   output logic              done,
   output logic              iss_valid,
   output logic [IW-1:0]     iss_idx,
   output logic              iss_sub,
   input  logic              iss_stall,
   input  logic [RES_W-1:0]  res,
   output logic              wr_en,
   output logic [IW-1:0]     wr_idx,
   output logic [DATA_W-1:0] wr_data
`ifdef VFADD_SEQ_EXC_FLAG_EN
   ,
   output logic              exc_flag,
   output logic [IW:0]       exc_cnt
`endif
);

   localparam int          CW      = $clog2(LAT + 1) + 1;
   localparam logic [IW:0] VL_MAX  = (IW + 1)'(MAX_VL);
   localparam logic [IW:0] VL_ONE  = (IW + 1)'(1);

   seq_state_t    state_q, state_d;
   logic [IW:0]   vl_q;
   logic          sub_q;
   logic [IW:0]   iss_cnt_q;
   logic [IW:0]   wr_cnt_q;
   logic          last_cons_q;
   logic [CW-1:0] outst_cnt;

   res_t          res_s;
   logic [IW:0]   vl_sat;
   logic [IW:0]   vl_last;
   logic          start_acc;
   logic          issue;
   logic          last_issue;
   logic          accept;

   assign res_s     = res_t'(res);
   assign vl_sat    = (vl > VL_MAX) ? VL_MAX : vl;
   assign vl_last   = vl_q - VL_ONE;
   assign start_acc = start && (state_q == IDLE);

   // Issue is also bounded by the latched length so the counter can never run past vl.
   assign issue      = (state_q == ISSUE) && !iss_stall && (iss_cnt_q != vl_q);
   assign last_issue = issue && (iss_cnt_q == vl_last);

   // A result with nothing outstanding (e.g. after an abort) is a protocol error and is dropped.
   assign accept = res_s.vld && (outst_cnt != '0) && (wr_cnt_q != vl_q);

   vfadd_credit_cnt #(
      .CW (CW)
   ) u_credit (
      .clk (clk),
      .rst (rst),
      .clr (start_acc),
      .inc (issue),
      .dec (accept),
      .cnt (outst_cnt)
   );

   // Next state and command-level outputs
   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      iss_valid = 1'b0;
      iss_idx   = '0;
      iss_sub   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (vl == '0) ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            busy      = 1'b1;
            iss_valid = issue;
            iss_idx   = iss_cnt_q[IW-1:0];
            iss_sub   = sub_q;
            if (last_issue) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            // last_cons_q rises in the cycle the final write is presented,
            // so done lands one cycle after that write.
            if (last_cons_q) begin
               state_d = FIN;
            end
         end
         FIN: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Hold every command output low while reset is asserted.
      if (rst) begin
         busy      = 1'b0;
         done      = 1'b0;
         iss_valid = 1'b0;
         iss_idx   = '0;
         iss_sub   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      state_q <= (rst) ? IDLE : state_d;
   end

   // Command latch, issue/write counters and the registered write port
   always_ff @(posedge clk) begin
      if (rst) begin
         vl_q        <= '0;
         sub_q       <= 1'b0;
         iss_cnt_q   <= '0;
         wr_cnt_q    <= '0;
         last_cons_q <= 1'b0;
         wr_en       <= 1'b0;
         wr_idx      <= '0;
         wr_data     <= '0;
      end else begin
         if (start_acc) begin
            vl_q        <= vl_sat;
            sub_q       <= op_sub;
            iss_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            last_cons_q <= 1'b0;
         end else begin
            if (issue) begin
               iss_cnt_q <= iss_cnt_q + VL_ONE;
            end
            if (accept) begin
               wr_cnt_q <= wr_cnt_q + VL_ONE;
            end
            last_cons_q <= accept && (wr_cnt_q == vl_last);
         end

         // Masked-off results advance the write counter but never strobe the register file.
         wr_en <= accept && res_s.mask;
         if (accept && res_s.mask) begin
            wr_idx  <= wr_cnt_q[IW-1:0];
            wr_data <= res_s.dat;
         end
      end
   end

`ifdef VFADD_SEQ_EXC_FLAG_EN
   logic [IW:0] exc_cnt_q;

   // Counts accepted Inf/NaN results; cleared by the next command, held after done.
   always_ff @(posedge clk) begin
      if (rst) begin
         exc_cnt_q <= '0;
      end else if (start_acc) begin
         exc_cnt_q <= '0;
      end else if (accept && is_exc(res_s)) begin
         exc_cnt_q <= exc_cnt_q + VL_ONE;
      end
   end

   assign exc_cnt  = exc_cnt_q;
   assign exc_flag = (exc_cnt_q != '0);
`endif

endmodule

// File: tb/tb_vfadd_sequencer.sv
// Self-checking bench for vfadd_sequencer with a fixed-latency lane model.
// Latency: lane returns each issued element LAT cycles after issue.
// Backpressure: iss_stall driven from per-command stall patterns.
module tb_vfadd_sequencer;

   localparam int MAX_VL = 32;
   localparam int LAT    = 3;
   localparam int IW     = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [IW:0]   vl;
   logic          op_sub;
   logic          busy;
   logic          done;
   logic          iss_valid;
   logic [IW-1:0] iss_idx;
   logic          iss_sub;
   logic          iss_stall;
   logic [33:0]   res;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [31:0]   wr_data;
`ifdef VFADD_SEQ_EXC_FLAG_EN
   logic          exc_flag;
   logic [IW:0]   exc_cnt;
`endif

   always #5 clk = ~clk;

   vfadd_sequencer #(
      .MAX_VL (MAX_VL),
      .LAT    (LAT),
      .IW     (IW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .vl        (vl),
      .op_sub    (op_sub),
      .busy      (busy),
      .done      (done),
      .iss_valid (iss_valid),
      .iss_idx   (iss_idx),
      .iss_sub   (iss_sub),
      .iss_stall (iss_stall),
      .res       (res),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data)
`ifdef VFADD_SEQ_EXC_FLAG_EN
      ,
      .exc_flag  (exc_flag),
      .exc_cnt   (exc_cnt)
`endif
   );

   // Lane model: fixed LAT-cycle pipeline. Masked-on elements carry a tagged value;
   // masked-off odd elements carry zero data (Inf/NaN encoding), even ones a non-zero tag.
   logic [31:0] cur_mask;
   logic        man_en;
   logic [33:0] man_res;
   logic [33:0] pipe [LAT];

   initial begin
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
   end

   always @(posedge clk) begin
      if (iss_valid) begin
         if (cur_mask[iss_idx])
            pipe[0] <= {1'b1, 1'b1, 8'hA5, 7'h0, iss_sub, 11'h0, iss_idx};
         else
            pipe[0] <= {1'b1, 1'b0, (iss_idx[0] ? 32'h0 : (32'hDEAD_0000 | 32'(iss_idx)))};
      end else begin
         pipe[0] <= '0;
      end
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign res = man_en ? man_res : pipe[LAT-1];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},    64'(busy),      64'd0);
      chk({tag, "_done"},    64'(done),      64'd0);
      chk({tag, "_iss_vld"}, 64'(iss_valid), 64'd0);
      chk({tag, "_iss_idx"}, 64'(iss_idx),   64'd0);
      chk({tag, "_iss_sub"}, 64'(iss_sub),   64'd0);
      chk({tag, "_wr_en"},   64'(wr_en),     64'd0);
      chk({tag, "_wr_idx"},  64'(wr_idx),    64'd0);
      chk({tag, "_wr_data"}, 64'(wr_data),   64'd0);
   endtask

   // One command: vl/op_sub/mask/stall inputs, optional second start (ignored), and the
   // hand-computed done cycle (counted from the start cycle), issue count, written-index map
   // and Inf/NaN count.
   typedef struct {
      int          vl;
      logic        sub;
      logic [31:0] mask;
      logic [15:0] stall;
      int          rs_cyc;
      int          done_cyc;
      int          n_iss;
      logic [31:0] wr_map;
      int          exc;
   } vec_t;

   vec_t vecs [9];

   task automatic run_cmd(input vec_t v, input int id);
      int          done_at = -1;
      int          extra_done = 0;
      int          n_iss = 0;
      int          last_w = -1;
      logic [31:0] wmap = '0;
      logic        exp_busy;
      cur_mask = v.mask;
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk);
         start     = (cyc == 0) || (v.rs_cyc != 0 && cyc == v.rs_cyc);
         vl        = (cyc == 0) ? (IW+1)'(v.vl) : (IW+1)'(7);
         op_sub    = (cyc == 0) ? v.sub : ~v.sub;
         iss_stall = (cyc < 16) ? v.stall[cyc] : 1'b0;
         #1;
         exp_busy = (cyc >= 1) && (done_at < 0);
         if (done) begin
            if (done_at < 0) done_at = cyc;
            else extra_done++;
         end
         chk($sformatf("v%0d_busy_c%0d", id, cyc), 64'(busy), 64'(exp_busy));
         if (iss_stall) chk($sformatf("v%0d_stall_blocks", id), 64'(iss_valid), 64'd0);
         if (iss_valid) begin
            chk($sformatf("v%0d_iss_idx", id), 64'(iss_idx), 64'(n_iss));
            chk($sformatf("v%0d_iss_sub", id), 64'(iss_sub), 64'(v.sub));
            n_iss++;
         end
         if (wr_en) begin
            chk($sformatf("v%0d_wr_order", id), 64'(int'(wr_idx) > last_w), 64'd1);
            chk($sformatf("v%0d_wr_data", id), 64'(wr_data),
                64'(32'hA500_0000 | (32'(v.sub) << 16) | 32'(wr_idx)));
            last_w = int'(wr_idx);
            wmap[wr_idx] = 1'b1;
         end
         if (done_at >= 0 && cyc >= done_at + 3) break;
      end
      start = 1'b0;
      chk($sformatf("v%0d_done_cyc", id), 64'(done_at), 64'(v.done_cyc));
      chk($sformatf("v%0d_done_once", id), 64'(extra_done), 64'd0);
      chk($sformatf("v%0d_n_iss", id), 64'(n_iss), 64'(v.n_iss));
      chk($sformatf("v%0d_wr_map", id), 64'(wmap), 64'(v.wr_map));
`ifdef VFADD_SEQ_EXC_FLAG_EN
      chk($sformatf("v%0d_exc_cnt", id), 64'(exc_cnt), 64'(v.exc));
      chk($sformatf("v%0d_exc_flag", id), 64'(exc_flag), 64'(v.exc != 0));
`endif
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; vl = '0; op_sub = 1'b0; iss_stall = 1'b0;
      man_en = 1'b0; man_res = '0; cur_mask = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk_all_zero("rst");
      @(negedge clk);
      rst = 1'b0;

      //           vl  sub   mask           stall     rs  done iss wr_map         exc
      vecs[0] = '{4,  1'b0, 32'h0000_000F, 16'h0000, 0,  9,   4,  32'h0000_000F, 0};
      vecs[1] = '{0,  1'b0, 32'h0000_0000, 16'h0000, 0,  1,   0,  32'h0000_0000, 0};
      vecs[2] = '{3,  1'b1, 32'h0000_0007, 16'h0004, 0,  9,   3,  32'h0000_0007, 0};
      vecs[3] = '{2,  1'b0, 32'h0000_0001, 16'h0000, 0,  7,   2,  32'h0000_0001, 1};
      vecs[4] = '{40, 1'b1, 32'hFFFF_FFFF, 16'h0000, 0,  37,  32, 32'hFFFF_FFFF, 0};
      vecs[5] = '{5,  1'b0, 32'h0000_0014, 16'h000A, 0,  12,  5,  32'h0000_0014, 2};
      vecs[6] = '{3,  1'b0, 32'h0000_0007, 16'h0000, 2,  8,   3,  32'h0000_0007, 0};
      vecs[7] = '{1,  1'b1, 32'h0000_0001, 16'h0000, 6,  6,   1,  32'h0000_0001, 0};
      vecs[8] = '{4,  1'b0, 32'h0000_000A, 16'h0006, 0,  11,  4,  32'h0000_000A, 0};

      for (int i = 0; i < 9; i++) run_cmd(vecs[i], i);

      // Abort from DRAIN: vl=4 issues in cycles 1-4, DRAIN from cycle 5; reset in cycle 6.
      cur_mask = 32'hF;
      @(negedge clk);
      start = 1'b1; vl = (IW+1)'(4); op_sub = 1'b0; iss_stall = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1;
      chk("drain_busy", 64'(busy), 64'd1);
      chk("drain_no_iss", 64'(iss_valid), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_all_zero("abort");
      // The lane still returns idx 3, and a stray result is injected: neither may be written.
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         man_en  = (c == 3);
         man_res = {1'b1, 1'b1, 32'h1234_5678};
         #1;
         chk($sformatf("abort_no_wr_c%0d", c), 64'(wr_en), 64'd0);
         chk($sformatf("abort_no_done_c%0d", c), 64'(done), 64'd0);
      end
      man_en = 1'b0;

      // Normal operation after the abort
      run_cmd(vecs[0], 9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
